// File: rtl/aes_pkg.sv
// Shared AES state geometry: column-major 16-byte state, byte 0 in the top byte.
package aes_pkg;
    localparam int AES_NB      = 4;
    localparam int AES_STATE_W = 128;
    localparam int BYTE_W      = 8;

    typedef logic [AES_STATE_W-1:0] state_t;

    function automatic int byte_idx(input int r, input int c);
        return r + AES_NB * c;
    endfunction
endpackage

// File: rtl/inv_shift_rows.sv
// Combinational ShiftRows permutation; INV=1 rotates row r right by r, INV=0 left by r.
module inv_shift_rows
    import aes_pkg::*;
#(
    parameter int INV = 1
) (
    input  logic [127:0] in_state,
    output logic [127:0] out_state
);
    for (genvar r = 0; r < AES_NB; r++) begin : g_row
        for (genvar c = 0; c < AES_NB; c++) begin : g_col
            localparam int SRC_C = (INV != 0) ? ((c - r + AES_NB) % AES_NB) : ((c + r) % AES_NB);
            localparam int DST   = byte_idx(r, c);
            localparam int SRC   = byte_idx(r, SRC_C);
            assign out_state[AES_STATE_W-1-BYTE_W*DST -: BYTE_W] =
                in_state[AES_STATE_W-1-BYTE_W*SRC -: BYTE_W];
        end
    end
endmodule

// File: rtl/inv_shift_rows_stream.sv
// Byte-serial to 128-bit (Inv)ShiftRows stage with an assembly buffer and an output buffer.
module inv_shift_rows_stream
    import aes_pkg::*;
#(
    parameter int INV   = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_byte,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_state,
    output logic             frame_err,
    output logic [CNT_W-1:0] blk_cnt
);
    logic [3:0]       byte_cnt_q, byte_cnt_d;
    state_t           asm_q, asm_d;
    logic             asm_full_q, asm_full_d;
    logic             out_valid_q, out_valid_d;
    state_t           out_state_q, out_state_d;
    logic             frame_err_q, frame_err_d;
    logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;

    state_t asm_word, t_in, t_out;
    logic   accept, last_pos, complete, out_hs;

    assign in_ready = !asm_full_q;
    assign accept   = in_valid && !asm_full_q;
    assign last_pos = (byte_cnt_q == 4'd15);
    assign asm_word = {asm_q[AES_STATE_W-BYTE_W-1:0], in_byte};
    assign complete = accept && last_pos && in_last;
    assign out_hs   = out_valid_q && out_ready;

    // One transform serves both sources: while HOLD no byte is accepted, so asm_q is the source.
    assign t_in = asm_full_q ? asm_q : asm_word;

    inv_shift_rows #(.INV(INV)) u_perm (
        .in_state (t_in),
        .out_state(t_out)
    );

    always_comb begin
        byte_cnt_d  = byte_cnt_q;
        asm_d       = asm_q;
        asm_full_d  = asm_full_q;
        out_valid_d = out_valid_q;
        out_state_d = out_state_q;
        frame_err_d = 1'b0;
        blk_cnt_d   = blk_cnt_q;

        if (accept) begin
            asm_d       = asm_word;
            byte_cnt_d  = (in_last || last_pos) ? 4'd0 : byte_cnt_q + 4'd1;
            frame_err_d = (in_last != last_pos);
        end

        if (out_hs) begin
            blk_cnt_d = blk_cnt_q + 1'b1;
            if (asm_full_q) begin
                out_state_d = t_out;
                asm_full_d  = 1'b0;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        // A completing block either lands in the output buffer or parks in HOLD.
        if (complete) begin
            if (!out_valid_q || out_ready) begin
                out_state_d = t_out;
                out_valid_d = 1'b1;
            end else begin
                asm_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_q  <= '0;
            asm_q       <= '0;
            asm_full_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_state_q <= '0;
            frame_err_q <= 1'b0;
            blk_cnt_q   <= '0;
        end else begin
            byte_cnt_q  <= byte_cnt_d;
            asm_q       <= asm_d;
            asm_full_q  <= asm_full_d;
            out_valid_q <= out_valid_d;
            out_state_q <= out_state_d;
            frame_err_q <= frame_err_d;
            blk_cnt_q   <= blk_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign frame_err = frame_err_q;
    assign blk_cnt   = blk_cnt_q;
endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Directed bench: table of blocks with hand-computed transforms, plus stall/framing/reset sequences.
module tb_inv_shift_rows_stream;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_last, out_ready;
    logic [7:0]   in_byte;
    logic         in_ready, out_valid, frame_err;
    logic [127:0] out_state;
    logic [15:0]  blk_cnt;
    logic         in_ready_f, out_valid_f, frame_err_f;
    logic [127:0] out_state_f;
    logic [15:0]  blk_cnt_f;

    always #5 clk = ~clk;

    inv_shift_rows_stream #(.INV(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_byte(in_byte), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_state(out_state), .frame_err(frame_err),
        .blk_cnt(blk_cnt)
    );

    inv_shift_rows_stream #(.INV(0), .CNT_W(16)) dut_fwd (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_f),
        .in_byte(in_byte), .in_last(in_last), .out_valid(out_valid_f),
        .out_ready(out_ready), .out_state(out_state_f), .frame_err(frame_err_f),
        .blk_cnt(blk_cnt_f)
    );

    typedef struct {
        logic [7:0]   base;
        logic [127:0] exp_inv;
        logic [127:0] exp_fwd;
    } vec_t;

    vec_t vecs[3];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_byte = 8'h00;
        step();
        rst = 1'b0;
    endtask

    // Streams n bytes base, base+1, ...; in_last on position last_at.
    task automatic send_bytes(input logic [7:0] base, input int n, input int last_at);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_byte  = base + 8'(k);
            in_last  = (k == last_at);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        int low_cnt;
        int exp_blk;
        vecs[0] = '{8'h00, 128'h000d0a07_04010e0b_0805020f_0c090603, 128'h00050a0f_04090e03_080d0207_0c01060b};
        vecs[1] = '{8'h10, 128'h101d1a17_14111e1b_1815121f_1c191613, 128'h10151a1f_14191e13_181d1217_1c11161b};
        vecs[2] = '{8'hf0, 128'hf0fdfaf7_f4f1fefb_f8f5f2ff_fcf9f6f3, 128'hf0f5faff_f4f9fef3_f8fdf2f7_fcf1f6fb};

        out_ready = 1'b1;
        do_reset();
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_state", out_state, 128'(0));
        check("rst_frame_err", 128'(frame_err), 128'(0));
        check("rst_blk_cnt", 128'(blk_cnt), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));

        // Table: one block each, output one cycle after the 16th byte.
        exp_blk = 0;
        for (int i = 0; i < 3; i++) begin
            send_bytes(vecs[i].base, 16, 15);
            check("tbl_out_valid", 128'(out_valid), 128'(1));
            check("tbl_state_inv", out_state, vecs[i].exp_inv);
            check("tbl_state_fwd", out_state_f, vecs[i].exp_fwd);
            check("tbl_blk_before", 128'(blk_cnt), 128'(exp_blk));
            step();
            exp_blk++;
            check("tbl_blk_after", 128'(blk_cnt), 128'(exp_blk));
            check("tbl_valid_clr", 128'(out_valid), 128'(0));
        end

        // Backpressure: A held, B parks in assembly buffer.
        do_reset();
        out_ready = 1'b0;
        send_bytes(8'h00, 16, 15);
        send_bytes(8'h10, 16, 15);
        check("hold_in_ready", 128'(in_ready), 128'(0));
        check("hold_state_a", out_state, vecs[0].exp_inv);
        step();
        check("hold_stable", out_state, vecs[0].exp_inv);
        check("hold_valid", 128'(out_valid), 128'(1));
        out_ready = 1'b1;
        step();
        check("hold_state_b", out_state, vecs[1].exp_inv);
        check("hold_valid_b", 128'(out_valid), 128'(1));
        check("hold_in_ready1", 128'(in_ready), 128'(1));
        check("hold_blk1", 128'(blk_cnt), 128'(1));
        step();
        check("hold_blk2", 128'(blk_cnt), 128'(2));
        check("hold_drain", 128'(out_valid), 128'(0));

        // Back-to-back; block 1 finishes exactly as block 0 is taken (swap, no bubble).
        do_reset();
        low_cnt = 0;
        for (int k = 0; k < 48; k++) begin
            out_ready = !(k >= 16 && k < 31);
            in_valid  = 1'b1;
            in_byte   = vecs[k/16].base + 8'(k % 16);
            in_last   = (k % 16 == 15);
            if (!in_ready) low_cnt++;
            step();
            if (k % 16 == 15) begin
                check("b2b_valid", 128'(out_valid), 128'(1));
                check("b2b_state", out_state, vecs[k/16].exp_inv);
            end
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        check("b2b_in_ready_low", 128'(low_cnt), 128'(0));
        check("b2b_blk_mid", 128'(blk_cnt), 128'(2));
        step();
        check("b2b_blk_end", 128'(blk_cnt), 128'(3));

        // Early in_last on the 5th byte.
        do_reset();
        send_bytes(8'h40, 5, 4);
        check("early_err", 128'(frame_err), 128'(1));
        check("early_noval", 128'(out_valid), 128'(0));
        step();
        check("early_pulse1", 128'(frame_err), 128'(0));
        send_bytes(8'h00, 16, 15);
        check("early_recover", out_state, vecs[0].exp_inv);
        check("early_rec_valid", 128'(out_valid), 128'(1));
        step();

        // Missing in_last on the 16th byte.
        send_bytes(8'h10, 16, 99);
        check("nolast_err", 128'(frame_err), 128'(1));
        check("nolast_noval", 128'(out_valid), 128'(0));
        send_bytes(8'h10, 16, 15);
        check("nolast_recover", out_state, vecs[1].exp_inv);
        step();

        // Reset mid-block, with bytes still offered during reset.
        do_reset();
        send_bytes(8'h30, 7, 99);
        rst = 1'b1; in_valid = 1'b1; in_byte = 8'h55;
        step();
        rst = 1'b0; in_valid = 1'b0;
        check("mrst_valid", 128'(out_valid), 128'(0));
        check("mrst_state", out_state, 128'(0));
        check("mrst_blk", 128'(blk_cnt), 128'(0));
        check("mrst_err", 128'(frame_err), 128'(0));
        send_bytes(8'hf0, 16, 15);
        check("mrst_new_state", out_state, vecs[2].exp_inv);
        check("mrst_new_err", 128'(frame_err), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
